// File: rtl/nwg_pkg.sv
// Shared types for the nwg word packer: the 12-bit packed word, the 3-bit lane value
// and the number of beats that make up one word.
package nwg_pkg;

    typedef logic [1:3][2:1][0:1] nwg_t;
    typedef logic [1:1][1:1][4:2] lane_t;

    localparam int NWG_BEATS = 6;

endpackage

// File: rtl/nwg_packer.sv
// Packs six 2-bit beats into one nwg_t word, MSB element first, and hands the word
// plus its lane values downstream through a single valid/ready output register.
module nwg_packer
    import nwg_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:1]       in_beat,
    input  lane_t            in_lane   [2:3],
    input  logic             in_flush,
    output nwg_t             nwg,
    output lane_t            lqywimfag [2:3],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [2:0] LAST_IDX = 3'(NWG_BEATS - 1);

    logic [2:0]       beat_idx_q, beat_idx_d;
    nwg_t             acc_q, acc_d;
    nwg_t             nwg_q, nwg_d;
    lane_t            lane_q [2:3];
    lane_t            lane_d [2:3];
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic       accept;
    logic       last_beat;
    logic       drain;
    logic [1:0] row_sel;
    logic [1:0] col_sel;

    // Only the closing beat can stall: it needs the output register free or draining.
    assign in_ready = !rst_n || !(beat_idx_q == LAST_IDX && out_valid_q && !out_ready);

    assign accept    = in_valid && in_ready && !in_flush;
    assign last_beat = accept && (beat_idx_q == LAST_IDX);
    assign drain     = out_valid_q && out_ready;
    assign row_sel   = beat_idx_q[2:1] + 2'd1;
    assign col_sel   = beat_idx_q[0] ? 2'd1 : 2'd2;

    always_comb begin
        beat_idx_d  = beat_idx_q;
        acc_d       = acc_q;
        nwg_d       = nwg_q;
        lane_d      = lane_q;
        out_valid_d = out_valid_q;
        word_cnt_d  = word_cnt_q;

        if (in_flush) begin
            beat_idx_d = 3'd0;
            acc_d      = '0;
        end else if (accept) begin
            acc_d[row_sel][col_sel] = in_beat;
            beat_idx_d = last_beat ? 3'd0 : beat_idx_q + 3'd1;
        end

        if (last_beat) begin
            nwg_d       = acc_d;
            lane_d      = in_lane;
            out_valid_d = 1'b1;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end

        if (drain) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_idx_q  <= 3'd0;
            acc_q       <= '0;
            nwg_q       <= '0;
            lane_q[2]   <= '0;
            lane_q[3]   <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            beat_idx_q  <= beat_idx_d;
            acc_q       <= acc_d;
            nwg_q       <= nwg_d;
            lane_q      <= lane_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign nwg       = nwg_q;
    assign lqywimfag = lane_q;
    assign out_valid = out_valid_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_nwg_packer.sv
// Directed bench for nwg_packer: a shift-register reference model fills a scoreboard
// queue as beats are accepted; words are popped and compared at each output handshake.
module tb_nwg_packer;
    import nwg_pkg::*;

    typedef struct {
        logic [11:0] w;
        logic [2:0]  l2;
        logic [2:0]  l3;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [0:1] in_beat = 2'b00;
    lane_t      in_lane [2:3];
    logic       in_flush = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, in_ready_s;
    nwg_t       nwg, nwg_s;
    lane_t      lqy [2:3];
    lane_t      lqy_s [2:3];
    logic       out_valid, out_valid_s;
    logic [7:0] word_cnt;
    logic [1:0] word_cnt_s;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb[$];
    int          m_idx = 0;
    logic [11:0] m_word = '0;
    int          m_cnt = 0;
    logic [11:0] last_nwg = '0;

    always #5 clk = ~clk;

    nwg_packer u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_beat(in_beat), .in_lane(in_lane), .in_flush(in_flush), .nwg(nwg),
        .lqywimfag(lqy), .out_valid(out_valid), .out_ready(out_ready), .word_cnt(word_cnt)
    );

    nwg_packer #(.CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_beat(in_beat), .in_lane(in_lane), .in_flush(in_flush), .nwg(nwg_s),
        .lqywimfag(lqy_s), .out_valid(out_valid_s), .out_ready(out_ready), .word_cnt(word_cnt_s)
    );

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model, return after the rise.
    task automatic tick(output logic accepted);
        logic exp_rdy;
        exp_t e;
        accepted = 1'b0;
        @(negedge clk);
        if (!rst_n) begin
            check("rst_in_ready", {11'd0, in_ready}, 12'd1);
            m_idx = 0;
            m_cnt = 0;
            sb.delete();
        end else begin
            exp_rdy = !(m_idx == 5 && sb.size() > 0 && !out_ready);
            check("in_ready", {11'd0, in_ready}, {11'd0, exp_rdy});
            check("out_valid", {11'd0, out_valid}, {11'd0, sb.size() > 0});
            check("word_cnt", {4'd0, word_cnt}, 12'(m_cnt % 256));
            check("word_cnt_c2", {10'd0, word_cnt_s}, 12'(m_cnt % 4));
            if (sb.size() > 0) begin
                check("nwg", nwg, sb[0].w);
                check("lane2", {9'd0, lqy[2]}, {9'd0, sb[0].l2});
                check("lane3", {9'd0, lqy[3]}, {9'd0, sb[0].l3});
                if (out_ready) begin
                    last_nwg = nwg;
                    e = sb.pop_front();
                    m_cnt++;
                end
            end
            if (in_flush) begin
                m_idx = 0;
            end else if (in_valid && exp_rdy) begin
                accepted = 1'b1;
                m_word = {m_word[9:0], in_beat};
                if (m_idx == 5) begin
                    e.w  = m_word;
                    e.l2 = in_lane[2];
                    e.l3 = in_lane[3];
                    sb.push_back(e);
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic send_beat(input logic [1:0] b);
        logic a;
        a = 1'b0;
        in_valid = 1'b1;
        in_beat  = b;
        for (int i = 0; i < 20 && !a; i++) tick(a);
        n_cmp++;
        assert (a) else begin
            n_err++;
            $error("FAIL beat_timeout observed=not_accepted expected=accepted");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] w, input logic [2:0] l2, input logic [2:0] l3);
        in_lane[2] = l2;
        in_lane[3] = l3;
        for (int k = 0; k < 6; k++) send_beat(w[11-2*k -: 2]);
    endtask

    initial begin
        logic a;
        logic [11:0] w;
        in_lane[2] = '0;
        in_lane[3] = '0;

        // reset state
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("rst_nwg", nwg, 12'h000);
        check("rst_lane", {6'd0, lqy[2], lqy[3]}, 12'h000);
        check("rst_valid", {11'd0, out_valid}, 12'd0);

        // basic word
        out_ready = 1'b1;
        send_word(12'h6C6, 3'b101, 3'b010);
        idle(3);
        check("word_6c6", last_nwg, 12'h6C6);
        check("cnt_after_6c6", {4'd0, word_cnt}, 12'd1);

        // backpressure: two words, closing beat of word 2 stalls
        out_ready = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (k == 6) begin
                in_lane[2] = 3'(($urandom));
                in_lane[3] = 3'(($urandom));
            end
            send_beat(2'($urandom));
        end
        in_valid = 1'b1;
        in_beat  = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick(a);
            check("stall_no_accept", {11'd0, a}, 12'd0);
        end
        out_ready = 1'b1;
        send_beat(2'b10);
        idle(3);
        check("cnt_after_stall", {4'd0, word_cnt}, 12'd3);

        // flush drops the partial word and the beat presented with it
        send_beat(2'b01);
        send_beat(2'b00);
        send_beat(2'b10);
        in_flush = 1'b1;
        in_valid = 1'b1;
        in_beat  = 2'b00;
        tick(a);
        in_flush = 1'b0;
        send_word(12'hFFF, 3'b111, 3'b001);
        idle(2);
        check("flush_fff", last_nwg, 12'hFFF);

        // reset mid-word, then a CNT_W=2 wrap over five drained words
        for (int k = 0; k < 4; k++) send_beat(2'b01);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        #1;
        check("midrst_valid", {11'd0, out_valid}, 12'd0);
        check("midrst_cnt", {4'd0, word_cnt}, 12'd0);
        check("midrst_ready", {11'd0, in_ready}, 12'd1);
        for (int n = 0; n < 5; n++) begin
            w = 12'($urandom);
            send_word(w, 3'(n), 3'(7 - n));
            idle(2);
            check("wrap_word", last_nwg, w);
            check("wrap_cnt_c2", {10'd0, word_cnt_s}, 12'((n + 1) % 4));
        end

        // X bits pass through unaltered
        in_lane[2] = 3'b011;
        in_lane[3] = 3'b100;
        send_beat(2'bx1);
        for (int k = 0; k < 5; k++) send_beat(2'b10);
        idle(2);
        check("x_beat", {10'd0, last_nwg[11:10]}, {10'd0, 2'bx1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
